// File: rtl/lsu_dmem_master_if.sv
// Bus bundles for the load/store unit: the core request/response channel
// and the byte-addressable data-memory port.
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface dmem_if;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  we;
  logic [31:0] drdata;

  modport master (output daddr, dwdata, we, input drdata);
  modport slave  (input daddr, dwdata, we, output drdata);
endinterface

// File: rtl/lsu_dmem_master.sv
// RV32 load/store unit driving a word-wide, byte-laned data memory; one request
// in flight, word-crossing accesses split into two memory cycles.
module lsu_dmem_master #(
  parameter int unsigned MEM_SIZE         = 10000000,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  lsu_req_if.slave   req,
  dmem_if.master     mem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC0 = 2'd1;
  localparam logic [1:0] S_ACC1 = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]  state;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] lo_q;
  logic [31:0] hi_q;

  logic [1:0]  lastoff_in;
  logic [32:0] last_in;
  logic        f3_bad, range_bad, mis_bad, err_in;

  always_comb begin
    case (req.req_funct3[1:0])
      2'b00:   lastoff_in = 2'd0;
      2'b01:   lastoff_in = 2'd1;
      default: lastoff_in = 2'd3;
    endcase
    f3_bad = (req.req_funct3 == 3'b011) || (req.req_funct3 == 3'b110) ||
             (req.req_funct3 == 3'b111) || (req.req_store && req.req_funct3[2]);
    // 33-bit sum so addresses near 2^32 cannot wrap back into range
    last_in   = {1'b0, req.req_addr} + {31'b0, lastoff_in};
    range_bad = (last_in >= 33'(MEM_SIZE));
    mis_bad   = !ALLOW_MISALIGNED &&
                (((req.req_funct3[1:0] == 2'b01) && req.req_addr[0]) ||
                 ((req.req_funct3[1:0] == 2'b10) && (req.req_addr[1:0] != 2'b00)));
    err_in    = f3_bad || range_bad || mis_bad;
  end

  logic [3:0]  lane;
  logic [7:0]  mask8;
  logic [63:0] data64;
  logic [31:0] r;
  logic [31:0] load_ext;

  always_comb begin
    case (f3_q[1:0])
      2'b00:   lane = 4'b0001;
      2'b01:   lane = 4'b0011;
      default: lane = 4'b1111;
    endcase
    mask8  = {4'b0, lane} << addr_q[1:0];
    data64 = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
    r      = 32'({hi_q, lo_q} >> {addr_q[1:0], 3'b000});
    case (f3_q)
      3'b000:  load_ext = {{24{r[7]}}, r[7:0]};
      3'b001:  load_ext = {{16{r[15]}}, r[15:0]};
      3'b010:  load_ext = r;
      3'b100:  load_ext = {24'b0, r[7:0]};
      3'b101:  load_ext = {16'b0, r[15:0]};
      default: load_ext = 32'b0;
    endcase
  end

  always_comb begin
    mem.daddr  = 32'b0;
    mem.dwdata = 32'b0;
    mem.we     = 4'b0;
    if (state == S_ACC0) begin
      mem.daddr = {addr_q[31:2], 2'b00};
      if (store_q) begin
        mem.we     = mask8[3:0];
        mem.dwdata = data64[31:0];
      end
    end else if (state == S_ACC1) begin
      mem.daddr = {addr_q[31:2], 2'b00} + 32'd4;
      if (store_q) begin
        mem.we     = mask8[7:4];
        mem.dwdata = data64[63:32];
      end
    end
    // a reset landing in ACC1 must not commit the high half on that edge
    if (rst) mem.we = 4'b0;
  end

  assign req.req_ready  = (state == S_IDLE);
  assign req.resp_valid = (state == S_RESP);
  assign req.resp_err   = (state == S_RESP) && err_q;
  assign req.resp_rdata = ((state == S_RESP) && !err_q && !store_q) ? load_ext : 32'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      store_q <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      err_q   <= 1'b0;
      lo_q    <= 32'b0;
      hi_q    <= 32'b0;
    end else begin
      case (state)
        S_IDLE: if (req.req_valid) begin
          store_q <= req.req_store;
          f3_q    <= req.req_funct3;
          addr_q  <= req.req_addr;
          wdata_q <= req.req_wdata;
          err_q   <= err_in;
          lo_q    <= 32'b0;
          hi_q    <= 32'b0;
          state   <= err_in ? S_RESP : S_ACC0;
        end
        S_ACC0: begin
          if (!store_q) lo_q <= mem.drdata;
          state <= (mask8[7:4] != 4'b0) ? S_ACC1 : S_RESP;
        end
        S_ACC1: begin
          if (!store_q) hi_q <= mem.drdata;
          state <= S_RESP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Scoreboard bench for lsu_dmem_master: one instance with misaligned splitting,
// one without, each backed by a small byte-array memory model.
module tb_lsu_dmem_master;
  localparam int unsigned MEM_SIZE = 10000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_req_if r0();
  lsu_req_if r1();
  dmem_if    m0();
  dmem_if    m1();

  lsu_dmem_master #(.MEM_SIZE(MEM_SIZE), .ALLOW_MISALIGNED(1'b1)) u0 (
    .clk(clk), .rst(rst), .req(r0), .mem(m0));
  lsu_dmem_master #(.MEM_SIZE(MEM_SIZE), .ALLOW_MISALIGNED(1'b0)) u1 (
    .clk(clk), .rst(rst), .req(r1), .mem(m1));

  logic        v = 1'b0, st = 1'b0, sel = 1'b0;
  logic [2:0]  f3 = 3'b0;
  logic [31:0] a = 32'b0, wd = 32'b0;

  assign r0.req_valid  = v & ~sel;
  assign r1.req_valid  = v & sel;
  assign r0.req_store  = st;
  assign r1.req_store  = st;
  assign r0.req_funct3 = f3;
  assign r1.req_funct3 = f3;
  assign r0.req_addr   = a;
  assign r1.req_addr   = a;
  assign r0.req_wdata  = wd;
  assign r1.req_wdata  = wd;

  logic        rdy;
  logic [3:0]  mwe;
  logic [31:0] mda, mdw;
  assign rdy = sel ? r1.req_ready : r0.req_ready;
  assign mwe = sel ? m1.we : m0.we;
  assign mda = sel ? m1.daddr : m0.daddr;
  assign mdw = sel ? m1.dwdata : m0.dwdata;

  logic [7:0] mem0 [0:4095] = '{default: 8'h00};
  logic [7:0] mem1 [0:4095] = '{default: 8'h00};

  assign m0.drdata = {mem0[{m0.daddr[11:2], 2'd3}], mem0[{m0.daddr[11:2], 2'd2}],
                      mem0[{m0.daddr[11:2], 2'd1}], mem0[{m0.daddr[11:2], 2'd0}]};
  assign m1.drdata = {mem1[{m1.daddr[11:2], 2'd3}], mem1[{m1.daddr[11:2], 2'd2}],
                      mem1[{m1.daddr[11:2], 2'd1}], mem1[{m1.daddr[11:2], 2'd0}]};

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (m0.we[i]) mem0[{m0.daddr[11:2], i[1:0]}] <= m0.dwdata[8*i +: 8];
      if (m1.we[i]) mem1[{m1.daddr[11:2], i[1:0]}] <= m1.dwdata[8*i +: 8];
    end
  end

  int cyc = 0, acc_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (v && rdy) acc_cyc <= cyc;
  end

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic got(input int id, input logic [31:0] rd, input logic er);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_resp dut=%0d rdata=0x%08h err=%0b", id, rd, er);
      return;
    end
    e = sbq.pop_front();
    chk("resp_dut", id, e.id);
    chk("resp_rdata", rd, e.rdata);
    chk("resp_err", {31'b0, er}, {31'b0, e.err});
    chk("resp_latency", cyc - acc_cyc, e.lat);
  endtask

  always @(negedge clk) begin
    if (r0.resp_valid) got(0, r0.resp_rdata, r0.resp_err);
    if (r1.resp_valid) got(1, r1.resp_rdata, r1.resp_err);
  end

  // mchk: 0 none, 1 check the cycle after accept, 2 also the following cycle
  task automatic issue(input int id, input logic s, input logic [2:0] fn,
                       input logic [31:0] ad, input logic [31:0] d,
                       input logic [31:0] er, input logic ee, input int el,
                       input int mchk,
                       input logic [3:0] we0, input logic [31:0] da0, input logic [31:0] dw0,
                       input logic [3:0] we1, input logic [31:0] da1, input logic [31:0] dw1);
    exp_t e;
    int   n;
    sel = (id == 1); st = s; f3 = fn; a = ad; wd = d;
    #1;
    n = 0;
    while (!rdy && n < 20) begin @(negedge clk); #1; n++; end
    if (!rdy) begin
      chk("ready_timeout", {31'b0, rdy}, 32'd1);
      return;
    end
    e.id = id; e.rdata = er; e.err = ee; e.lat = el;
    sbq.push_back(e);
    v = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v = 1'b0;
    if (mchk > 0) begin
      chk("acc0_we", {28'b0, mwe}, {28'b0, we0});
      chk("acc0_daddr", mda, da0);
      chk("acc0_dwdata", mdw, dw0);
    end
    if (mchk > 1) begin
      @(negedge clk);
      chk("acc1_we", {28'b0, mwe}, {28'b0, we1});
      chk("acc1_daddr", mda, da1);
      chk("acc1_dwdata", mdw, dw1);
    end
    n = 0;
    while (sbq.size() != 0 && n < 20) begin @(negedge clk); #1; n++; end
    if (sbq.size() != 0) begin
      chk("resp_timeout", sbq.size(), 32'd0);
      sbq.delete();
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", {31'b0, r0.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, r0.resp_valid}, 32'd0);
    chk("rst_rdata", r0.resp_rdata, 32'd0);
    chk("rst_err", {31'b0, r0.resp_err}, 32'd0);
    chk("rst_daddr", m0.daddr, 32'd0);
    chk("rst_dwdata", m0.dwdata, 32'd0);
    chk("rst_we", {28'b0, m0.we}, 32'd0);

    // id st f3 addr wdata | rdata err lat | mchk we0 da0 dw0 we1 da1 dw1
    issue(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 2, 1, 4'hF, 32'h100, 32'hDEADBEEF, 0, 0, 0);
    issue(0, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 2, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 1, 3'b000, 32'h103, 32'h123456A5, 0, 0, 2, 1, 4'h8, 32'h100, 32'hA5000000, 0, 0, 0);
    issue(0, 0, 3'b000, 32'h103, 0, 32'hFFFFFFA5, 0, 2, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 3'b100, 32'h103, 0, 32'h000000A5, 0, 2, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 3'b010, 32'h100, 0, 32'hA5ADBEEF, 0, 2, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 3'b001, 32'h102, 0, 32'hFFFFA5AD, 0, 2, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 1, 3'b010, 32'h106, 32'h11223344, 0, 0, 3, 2,
          4'hC, 32'h104, 32'h33440000, 4'h3, 32'h108, 32'h00001122);
    issue(0, 0, 3'b010, 32'h106, 0, 32'h11223344, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 3'b101, 32'h107, 0, 32'h00002233, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 3'b000, 32'h109, 0, 32'h00000011, 0, 2, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 3'b010, MEM_SIZE - 2, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 3'b010, 32'hFFFFFFFE, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 3'b011, 32'h100, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    issue(0, 1, 3'b100, 32'h100, 32'hFFFFFFFF, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 3'b110, 32'h100, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 3'b010, 32'h100, 0, 32'hA5ADBEEF, 0, 2, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 1, 3'b001, 32'h202, 32'h00008001, 0, 0, 2, 1, 4'hC, 32'h200, 32'h80010000, 0, 0, 0);
    issue(1, 0, 3'b001, 32'h202, 0, 32'hFFFF8001, 0, 2, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 3'b010, 32'h202, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 3'b001, 32'h201, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);

    // reset in ACC1 of a split store: low half lands, high half does not
    repeat (2) @(negedge clk);
    sel = 1'b0; st = 1'b1; f3 = 3'b010; a = 32'h30E; wd = 32'h55667788;
    #1;
    chk("rst_test_ready", {31'b0, rdy}, 32'd1);
    v = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v = 1'b0;
    @(negedge clk);
    chk("rst_test_acc1_we", {28'b0, m0.we}, 32'h3);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'b0, r0.req_ready}, 32'd1);
    chk("abort_we", {28'b0, m0.we}, 32'd0);
    chk("abort_resp_valid", {31'b0, r0.resp_valid}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_byte30e", {24'b0, mem0[12'h30E]}, 32'h88);
    chk("abort_byte30f", {24'b0, mem0[12'h30F]}, 32'h77);
    chk("abort_byte310", {24'b0, mem0[12'h310]}, 32'h00);
    chk("abort_byte311", {24'b0, mem0[12'h311]}, 32'h00);
    issue(0, 0, 3'b010, 32'h30C, 0, 32'h77880000, 0, 2, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 3'b010, 32'h310, 0, 32'h00000000, 0, 2, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
- Load/store unit on the CPU side of the data-memory port; it is the initiator for the byte-addressable data memory.
- Accepts one RV32 load/store request at a time from the core and drives daddr/dwdata/we to memory.
- Reads are combinational: drdata is valid in the same cycle as daddr. Writes commit on the next posedge clk.
- Splits word-crossing misaligned accesses into two memory cycles, then returns the extended load data or a store completion.

Parameters:
- MEM_SIZE, 10000000: memory size in bytes. Any access whose last byte address is ≥ MEM_SIZE is an error.
- ALLOW_MISALIGNED, 1: 1 = split word-crossing accesses into two cycles; 0 = misaligned access (addr not a multiple of size) is an error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  unit can accept a request
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  error flag, valid with resp_valid
- daddr  out  32  memory address, always word-aligned
- dwdata  out  32  memory write data
- we  out  4  memory byte-lane write enables
- drdata  in  32  memory read data (combinational)

Behaviour:
- Reset: state IDLE. req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, daddr=0, dwdata=0, we=0.
- Memory outputs are 0 in every state other than ACC0/ACC1.
- States: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch store, funct3, addr and wdata.
  - Error if any of: funct3 illegal (011, 110, 111, or 100/101 with store); out of range; misaligned with ALLOW_MISALIGNED=0. An error goes to RESP with err=1 and performs no memory access.
  - Otherwise go to ACC0.
- Size and lanes:
  - n = 1/2/4 from funct3[1:0]; o = addr[1:0].
  - mask8 = ((1<<n)-1) << o (8-bit).
  - data64 = {32'b0, wdata} << (8*o).
- ACC0:
  - daddr = addr & ~3.
  - Store: we = mask8[3:0], dwdata = data64[31:0].
  - Load: capture drdata into low buffer word, we=0.
  - If mask8[7:4] != 0 go to ACC1, else RESP.
- ACC1:
  - daddr = (addr & ~3) + 4.
  - Store: we = mask8[7:4], dwdata = data64[63:32].
  - Load: capture drdata into high buffer word.
  - Go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0.
  - Load result: r = {hi, lo} >> (8*o). Sign-extend r[7:0] or r[15:0] for B/H; zero-extend for BU/HU; W passes r[31:0].
  - Return to IDLE. The next request can be accepted in the following cycle.
- Latency from the accept edge to resp_valid:
  - 2 cycles for a single-word access.
  - 3 cycles for a word-crossing access.
  - 1 cycle for an error.
- Throughput: one request per 3 cycles when aligned.
- Range check: addr + n − 1 ≥ MEM_SIZE is an error. The 32-bit sum must not wrap; compute it in 33 bits.
- Reset mid-operation: the operation is aborted, and no resp_valid is issued for it. If the abort happens in ACC1, the ACC0 half of a split store has already committed; this partial write is accepted.
- req_valid while busy is ignored; the core must hold the request until req_ready.
- No response backpressure.

Test Plan:
- Aligned SW 0xDEADBEEF to 0x100, then LW 0x100 → ACC0 store drives we=4'b1111, daddr=0x100; LW resp_rdata=0xDEADBEEF, resp_valid 2 cycles after accept, resp_err=0.
- SB 0xA5 to 0x103, then LB 0x103 and LBU 0x103 → store drives we=4'b1000, dwdata[31:24]=0xA5; LB=0xFFFFFFA5, LBU=0x000000A5.
- Word-crossing SW 0x11223344 to 0x106 (ALLOW_MISALIGNED=1):
  - ACC0: daddr=0x104, we=4'b1100, dwdata=0x33440000.
  - ACC1: daddr=0x108, we=4'b0011, dwdata=0x00001122.
  - Follow-up LW 0x106 returns 0x11223344 with 3-cycle latency.
- LH 0x202 with ALLOW_MISALIGNED=0 is legal (aligned halfword); LW 0x202 → resp_err=1 after 1 cycle, we stays 0.
- Error cases, each giving resp_err=1, no memory access and resp_rdata=0:
  - LW at MEM_SIZE−2.
  - funct3=011.
  - Store with funct3=100.
- Assert rst during ACC1 of a split store → next cycle IDLE, we=0, req_ready=1, no resp_valid; low half bytes are written, high half bytes unchanged.
